// File: rtl/seg7_rx_checker.sv
// seg7_rx_checker: debounces a 7-segment bus, decodes digits, checks +1 sequencing and measures digit period.
// Optional build macro SEG7_HEX_EN adds A-F glyphs and switches the sequence check to modulo 16.
module seg7_rx_checker #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic                sample_en,
  output logic [3:0]          digit_out,
  output logic                digit_valid,
  output logic                invalid,
  output logic                seq_err,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [6:0]          s_reg_q, s_reg_d;
  logic [6:0]          last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [0:0]          state_q, state_d;
  logic [3:0]          digit_q, digit_d;
  logic                dv_q, dv_d;
  logic                inv_q, inv_d;
  logic                seq_q, seq_d;
  logic                pv_q, pv_d;
  logic [7:0]          err_q, err_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] per_inc;
  logic [3:0]          dec_digit;
  logic                dec_ok;
  logic [3:0]          next_digit;
  logic                same, acc, acc_ok, acc_bad, bad_seq;

`ifdef SEG7_HEX_EN
  assign next_digit = digit_q + 4'd1;
`else
  assign next_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
`endif

  // Decode the debounced pattern; anything outside the glyph table is a non-digit.
  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'd0;
    case (s_reg_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
`ifdef SEG7_HEX_EN
      7'h77: dec_digit = 4'd10;
      7'h7C: dec_digit = 4'd11;
      7'h39: dec_digit = 4'd12;
      7'h5E: dec_digit = 4'd13;
      7'h79: dec_digit = 4'd14;
      7'h71: dec_digit = 4'd15;
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  // Acceptance fires once per stable run, on the sample that extends a run already STABLE_CYCLES long.
  always_comb begin
    same      = seg_in == s_reg_q;
    acc       = sample_en && same && cnt_q == CW'(STABLE_CYCLES - 1) && s_reg_q != last_q;
    acc_ok    = acc && dec_ok;
    acc_bad   = acc && !dec_ok;
    bad_seq   = acc_ok && state_q == TRACK && dec_digit != next_digit;
    per_inc   = &per_cnt_q ? per_cnt_q : per_cnt_q + 1'b1;
    s_reg_d   = sample_en ? seg_in : s_reg_q;
    cnt_d     = !sample_en ? cnt_q : !same ? '0 : cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + 1'b1;
    last_d    = acc ? s_reg_q : last_q;
    state_d   = acc_ok ? TRACK : state_q;
    digit_d   = acc_ok ? dec_digit : digit_q;
    dv_d      = acc_ok;
    inv_d     = acc_bad;
    seq_d     = bad_seq;
    pv_d      = acc_ok && state_q == TRACK;
    per_cnt_d = !sample_en ? per_cnt_q : acc_ok ? '0 : per_inc;
    period_d  = pv_d ? per_inc : period_q;
    err_d     = ((acc_bad || bad_seq) && !(&err_q)) ? err_q + 8'd1 : err_q;
  end

  // State registers; reset overrides sample_en, pulses are cleared whenever sampling is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      digit_q   <= '0;
      dv_q      <= 1'b0;
      inv_q     <= 1'b0;
      seq_q     <= 1'b0;
      pv_q      <= 1'b0;
      err_q     <= '0;
      per_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      s_reg_q   <= s_reg_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      digit_q   <= digit_d;
      dv_q      <= dv_d;
      inv_q     <= inv_d;
      seq_q     <= seq_d;
      pv_q      <= pv_d;
      err_q     <= err_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
    end
  end

  assign digit_out    = digit_q;
  assign digit_valid  = dv_q;
  assign invalid      = inv_q;
  assign seq_err      = seq_q;
  assign err_count    = err_q;
  assign period_out   = period_q;
  assign period_valid = pv_q;
endmodule

// File: doc/seg7_rx_checker.md
Name: seg7_rx_checker

Overview:
- Receive-side counterpart of the seven-segment seconds counter.
- Samples a 7-bit segment bus, debounces it, and decodes stable patterns back to a digit.
- Checks that successive digits increment modulo 10 and measures the cycle count between digit changes.
- Used as an on-chip monitor and loopback checker: its segment input is driven from the counter's uo_out[6:0].

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (min 1).
- PERIOD_W, 24, width of the digit-period counter and period_out.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active-high
- sample_en  input  1  when high, the block samples and advances; when low, all state is frozen
- digit_out  output  4  last accepted digit
- digit_valid  output  1  one-cycle pulse when a new digit is accepted
- invalid  output  1  one-cycle pulse when a stable non-digit pattern is accepted
- seq_err  output  1  one-cycle pulse, coincident with digit_valid, on a sequence violation
- err_count  output  8  saturating count of invalid + seq_err events
- period_out  output  PERIOD_W  cycles between the last two accepted digits
- period_valid  output  1  one-cycle pulse, coincident with digit_valid, from the 2nd digit on

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, last-accepted pattern register = 0x00, stability counter 0, period counter 0. Reset always wins over sample_en.
- Decode table: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9. Any other pattern, including 0x00, is invalid.
- Pipeline:
  - s_reg <= seg_in every enabled cycle.
  - Stability counter clears when s_reg differs from its previous value; otherwise it increments, saturating at STABLE_CYCLES.
- Acceptance: occurs on the cycle the counter reaches STABLE_CYCLES-1 with an unchanged sample, and only if s_reg differs from the last-accepted pattern.
  - Latency: a pattern first present at sample edge 0 and held produces its pulse in cycle STABLE_CYCLES+1 (cycle 5 at default).
- Re-acceptance: a pattern equal to the last accepted one is never re-reported. A glitch that disappears before STABLE_CYCLES samples produces nothing.
- FSM states:
  - IDLE: no digit yet. The first valid acceptance sets digit_out, pulses digit_valid, performs no sequence check, and moves to TRACK.
  - TRACK: each valid acceptance is checked against (digit_out+1) mod 10. On mismatch, seq_err pulses. digit_out always updates to the new digit.
- Invalid acceptance (either state): pulses invalid, increments err_count, and leaves digit_out and the FSM state unchanged. The last-accepted pattern does update, so a held blank reports once.
- err_count: +1 per invalid or seq_err; the two cannot occur in the same cycle. Saturates at 255.
- Period counter:
  - Increments every enabled cycle and saturates at all-ones.
  - On each valid acceptance: period_out <= counter+1 (or saturated value), then the counter clears.
  - period_valid pulses only in TRACK, i.e. from the 2nd digit on.
- sample_en low:
  - s_reg, stability counter, period counter, FSM and all registers hold.
  - Pulse outputs are forced 0.
- Reset mid-operation: everything returns to the reset values. The first digit after reset is unchecked and produces no period.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: the decode table adds A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71, and the sequence check becomes (digit_out+1) mod 16.
- Undefined: these patterns are invalid and the check is mod 10.

Test Plan:
- Reset, then hold 0x3F for 10 cycles -> digit_valid once at cycle 5, digit_out=0, seq_err=0, period_valid=0.
- Drive 0x3F, 0x06, 0x5B, each held 20 cycles -> digits 0,1,2; period_valid with period_out=20 on the 2nd and 3rd digits; err_count=0.
- After accepting digit 3 (0x4F), apply 0x6D (5) for 8 cycles -> digit_valid and seq_err pulse together, digit_out=5, err_count=1.
- Insert a 3-cycle glitch 0x7F between stable 0x3F and 0x06 -> no acceptance of 8; next accepted digit is 1.
- Hold 0x00 for 10 cycles after digit 2 -> invalid pulses once, digit_out stays 2, err_count +1; then 0x4F -> digit 3 with no seq_err.
- Drop sample_en for 50 cycles mid-hold, then assert rst for 1 cycle -> no pulses while frozen; after reset all outputs 0 and the first digit is unchecked.
